// File: rtl/rep_serial_pkg.sv
// Shared types and helpers for the repetition-coded serial transmitter.
// Holds the FSM state encoding, default geometry and frame-length arithmetic.
package rep_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_REP    = 3;

   // Number of valid line cycles in one frame, parity bit included when enabled.
   function automatic int frame_len(input int data_w, input int rep, input bit parity);
      return (data_w + (parity ? 1 : 0)) * rep;
   endfunction

endpackage

// File: rtl/rep_counter.sv
// Modulo-REP repetition counter; tc is high while the count sits at REP-1.
// Latency: count updates on the clock edge; no backpressure, enable-gated only.
module rep_counter #(
   parameter int REP = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (REP > 1) ? $clog2(REP) : 1;

   logic [CW-1:0] cnt;

   assign tc = (cnt == CW'(REP - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/rep_serial_tx.sv
// Repetition-coded serial transmitter: LSB first, each bit held REP cycles, then a done pulse.
// Optional even parity bit after the MSB when REP_SERIAL_TX_PARITY_EN is defined.
module rep_serial_tx
   import rep_serial_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REP    = DEF_REP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              tx_out,
   output logic              tx_valid,
   output logic              done
);

`ifdef REP_SERIAL_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam int NBITS = frame_len(DATA_W, REP, PAR_EN) / REP;
   localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;

   state_t           state, state_nxt;
   logic [NBITS-1:0] shreg, shreg_nxt, load_word;
   logic [BW-1:0]    bit_idx, bit_nxt;
   logic             rep_clr, rep_en, rep_tc;

`ifdef REP_SERIAL_TX_PARITY_EN
   assign load_word = {^data_in, data_in};
`else
   assign load_word = data_in;
`endif

   assign ready = (state == IDLE);

   rep_counter #(.REP(REP)) u_rep_counter (
      .clk (clk),
      .rst (rst),
      .clr (rep_clr),
      .en  (rep_en),
      .tc  (rep_tc)
   );

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      bit_nxt   = bit_idx;
      rep_clr   = 1'b0;
      rep_en    = 1'b0;
      unique case (state)
         IDLE: begin
            if (load) begin
               state_nxt = SEND;
               shreg_nxt = load_word;
               bit_nxt   = '0;
               rep_clr   = 1'b1;
            end
         end
         SEND: begin
            rep_en = 1'b1;
            if (rep_tc) begin
               if (bit_idx == BW'(NBITS - 1)) begin
                  state_nxt = DONE;
               end else begin
                  shreg_nxt = shreg >> 1;
                  bit_nxt   = bit_idx + BW'(1);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Line outputs are registered from the next-state view so they align with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         tx_out   <= 1'b0;
         tx_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         bit_idx  <= bit_nxt;
         tx_valid <= (state_nxt == SEND);
         tx_out   <= (state_nxt == SEND) & shreg_nxt[0];
         done     <= (state_nxt == DONE);
      end
   end

endmodule
